ex4_2: RTL and testbench

//   4-bit modulo-16 adder with a registered result: y = (a + b) mod 16.

---
 rtl/ex4_2.sv | 83 ++++++++
 tb/tb_ex4_2.sv | 113 +++++++++++
 2 files changed

// File: rtl/ex4_2.sv
// ex4_2: 4-bit modulo-16 adder, y = (a + b) mod 16, built as a ripple-carry chain of full adders.
// Latency: 1 cycle; operands sampled on a rising clk edge appear on y right after that edge.
// Backpressure: none; a new sum is captured every cycle unless rst is high, which forces y to 0.

// One-bit full adder; the leaf cell of the ripple chain.
module ex4_2_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    always_comb begin
        p   = a_i ^ b_i;
        s_o = p ^ c_i;
        c_o = (a_i & b_i) | (c_i & p);
    end

endmodule

module ex4_2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // carry[i] is the carry into bit i; carry[0] is tied low.
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    // Carry out of the top bit is dropped so the result wraps modulo 2**WIDTH.
    logic             carry_unused;

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    assign carry[0] = 1'b0;

    // Ripple chain: each stage feeds its carry into the next higher bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < WIDTH - 1) begin : g_mid
            ex4_2_fa u_fa (
                .a_i (a[i]),
                .b_i (b[i]),
                .c_i (carry[i]),
                .s_o (sum[i]),
                .c_o (carry[i+1])
            );
        end else begin : g_top
            ex4_2_fa u_fa (
                .a_i (a[i]),
                .b_i (b[i]),
                .c_i (carry[i]),
                .s_o (sum[i]),
                .c_o (carry_unused)
            );
        end
    end

    // Next-state is simply the combinational sum; reset priority lives in the register.
    always_comb begin
        y_d = sum;
    end

    // Output register isolates the ripple path from downstream timing; sync reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_ex4_2.sv
// tb_ex4_2: directed and table-driven checks of the registered 4-bit wrap-around adder.
// Latency: expects each result one rising edge after its operands are applied.
// Backpressure: none; inputs change #1 after each rising edge and y is sampled there too.
module tb_ex4_2;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[7];

    ex4_2 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp);
        n_cmp++;
        if (y !== exp) begin
            n_bad++;
            $display("FAIL %s: y=%h expected %h", name, y, exp);
        end
    endtask

    // Apply operands/reset, let one rising edge pass, then look at y.
    task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv);
        rst = r;
        a   = av;
        b   = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a   = 4'h7;
        b   = 4'h5;

        vecs[0] = '{4'hF, 4'h1, 4'h0, "wrap_F_1"};
        vecs[1] = '{4'hF, 4'hF, 4'hE, "wrap_F_F"};
        vecs[2] = '{4'h8, 4'h8, 4'h0, "wrap_8_8"};
        vecs[3] = '{4'h0, 4'h0, 4'h0, "zero_0_0"};
        vecs[4] = '{4'h7, 4'h8, 4'hF, "edge_7_8"};
        vecs[5] = '{4'h3, 4'hC, 4'hF, "comm_3_C"};
        vecs[6] = '{4'hC, 4'h3, 4'hF, "comm_C_3"};

        // Reset held for two edges with non-zero operands, then release.
        step(1'b1, 4'h7, 4'h5);
        check("reset_edge1", 4'h0);
        step(1'b1, 4'h7, 4'h5);
        check("reset_edge2", 4'h0);
        step(1'b0, 4'h7, 4'h5);
        check("post_reset_7_5", 4'hC);

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [4:0] full;
                full = 5'(i) + 5'(j);
                step(1'b0, 4'(i), 4'(j));
                check($sformatf("sweep_%h_%h", i[3:0], j[3:0]), full[3:0]);
            end
        end

        // Wrap boundaries and commutativity from the vector table.
        for (int k = 0; k < 7; k++) begin
            step(1'b0, vecs[k].a, vecs[k].b);
            check(vecs[k].name, vecs[k].exp);
        end

        // Latency: a changes between edges, y must hold until the next edge.
        step(1'b0, 4'h3, 4'h2);
        check("lat_before", 4'h5);
        a = 4'h9;
        #3;
        check("lat_hold", 4'h5);
        @(posedge clk);
        #1;
        check("lat_after", 4'hB);

        // Reset in the middle of a stream discards the in-flight sum.
        step(1'b0, 4'h9, 4'h9);
        check("mid_pre", 4'h2);
        step(1'b1, 4'hA, 4'h9);
        check("mid_rst", 4'h0);
        step(1'b0, 4'hA, 4'h9);
        check("mid_release", 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
